// File: rtl/croc_gpio_in_filter_pkg.sv
// Shared constants and types for the GPIO input filter.
// The chip top and the GPIO register file also use these definitions.
package croc_gpio_in_filter_pkg;

    localparam int unsigned GpioFiltCount     = 32;
    localparam int unsigned GpioFiltCntWidth  = 8;

    typedef logic [GpioFiltCntWidth-1:0] gpio_filt_thresh_t;

    // Registered outputs of one filtered pin.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } gpio_filt_out_t;

endpackage

// File: rtl/croc_gpio_in_filter_if.sv
// Pad-side inputs, debounce configuration and filtered outputs of the GPIO input filter.
interface croc_gpio_in_filter_if
    import croc_gpio_in_filter_pkg::*;
#(
    parameter int unsigned GpioCount = GpioFiltCount,
    parameter int unsigned CntWidth  = GpioFiltCntWidth
);

    logic [GpioCount-1:0] pad_i;
    logic [GpioCount-1:0] filt_en_i;
    logic [CntWidth-1:0]  thresh_i;
    logic [GpioCount-1:0] gpio_o;
    logic [GpioCount-1:0] rise_o;
    logic [GpioCount-1:0] fall_o;

    modport master (
        output pad_i, filt_en_i, thresh_i,
        input  gpio_o, rise_o, fall_o
    );

    modport slave (
        input  pad_i, filt_en_i, thresh_i,
        output gpio_o, rise_o, fall_o
    );

endinterface

// File: rtl/croc_gpio_in_filter_cell.sv
// One pin of the GPIO input filter: synchroniser, debounce counter and edge-pulse flops,
// plus the tech-mappable synchroniser cell it instantiates.
module croc_gpio_sync #(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Depth-1:0] reg_d, reg_q;

    always_comb begin
        reg_d = {reg_q[Depth-2:0], d_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q_o = reg_q[Depth-1];

endmodule

module croc_gpio_filter_cell
    import croc_gpio_in_filter_pkg::*;
#(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned CntWidth   = GpioFiltCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pad_i,
    input  logic                filt_en_i,
    input  logic [CntWidth-1:0] thresh_i,
    output gpio_filt_out_t      out_o
);

    logic                sync_s;
    logic                stable_d, stable_q;
    logic [CntWidth-1:0] cnt_d, cnt_q;
    logic                rise_d, rise_q;
    logic                fall_d, fall_q;

    croc_gpio_sync #(
        .Depth (SyncStages)
    ) i_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pad_i),
        .q_o   (sync_s)
    );

    // The >= compare commits before cnt_q can pass the threshold, so it never wraps.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (!filt_en_i) begin
            stable_d = sync_s;
            cnt_d    = '0;
        end else if (sync_s == stable_q) begin
            cnt_d    = '0;
        end else if (cnt_q >= thresh_i) begin
            stable_d = sync_s;
            cnt_d    = '0;
        end else begin
            cnt_d    = cnt_q + CntWidth'(1);
        end
    end

    always_comb begin
        rise_d = ~stable_q &  stable_d;
        fall_d =  stable_q & ~stable_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign out_o = '{level: stable_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/croc_gpio_in_filter.sv
// GPIO input filter: synchronises and optionally debounces every pad input and
// reports registered rise/fall pulses for the GPIO interrupt logic.
module croc_gpio_in_filter
    import croc_gpio_in_filter_pkg::*;
#(
    parameter int unsigned GpioCount  = GpioFiltCount,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned CntWidth   = GpioFiltCntWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    croc_gpio_in_filter_if.slave  bus
);

    logic [GpioCount-1:0] gpio;
    logic [GpioCount-1:0] rise;
    logic [GpioCount-1:0] fall;

    for (genvar i = 0; i < GpioCount; i++) begin : g_pin
        gpio_filt_out_t cell_out;

        croc_gpio_filter_cell #(
            .SyncStages (SyncStages),
            .CntWidth   (CntWidth)
        ) i_cell (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .pad_i     (bus.pad_i[i]),
            .filt_en_i (bus.filt_en_i[i]),
            .thresh_i  (bus.thresh_i),
            .out_o     (cell_out)
        );

        assign gpio[i] = cell_out.level;
        assign rise[i] = cell_out.rise;
        assign fall[i] = cell_out.fall;
    end

    assign bus.gpio_o = gpio;
    assign bus.rise_o = rise;
    assign bus.fall_o = fall;

endmodule

// File: tb/tb_croc_gpio_in_filter.sv
// Bench for croc_gpio_in_filter: directed scenarios with literal expectations, then
// random pad/enable/threshold traffic compared every cycle against a run-length model.
module tb_croc_gpio_in_filter;
    import croc_gpio_in_filter_pkg::*;

    localparam int GpioCount  = 32;
    localparam int SyncStages = 2;
    localparam int CntWidth   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   checkEn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [GpioCount-1:0] padHist [SyncStages];
    logic [GpioCount-1:0] expGpio, expRise, expFall;
    int                   streak [GpioCount];

    croc_gpio_in_filter_if #(.GpioCount(GpioCount), .CntWidth(CntWidth)) bus ();

    croc_gpio_in_filter #(
        .GpioCount  (GpioCount),
        .SyncStages (SyncStages),
        .CntWidth   (CntWidth)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pad, input logic [31:0] en, input logic [7:0] thr);
        bus.pad_i     = pad;
        bus.filt_en_i = en;
        bus.thresh_i  = thr;
    endtask

    // Model: the synchronised level is the pad value seen SyncStages edges ago; a filtered
    // pin commits once it has differed from the output for more than thresh_i edges in a row.
    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int k = 0; k < SyncStages; k++) padHist[k] = '0;
            expGpio = '0;
            expRise = '0;
            expFall = '0;
            for (int i = 0; i < GpioCount; i++) streak[i] = 0;
        end else begin
            logic [GpioCount-1:0] syncVal;
            logic [GpioCount-1:0] prev;
            syncVal = padHist[SyncStages-1];
            prev    = expGpio;
            for (int i = 0; i < GpioCount; i++) begin
                if (!bus.filt_en_i[i]) begin
                    expGpio[i] = syncVal[i];
                    streak[i]  = 0;
                end else if (syncVal[i] != prev[i]) begin
                    streak[i] = streak[i] + 1;
                    if (streak[i] > int'(bus.thresh_i)) begin
                        expGpio[i] = syncVal[i];
                        streak[i]  = 0;
                    end
                end else begin
                    streak[i] = 0;
                end
            end
            expRise = expGpio & ~prev;
            expFall = prev & ~expGpio;
            for (int k = SyncStages - 1; k > 0; k--) padHist[k] = padHist[k-1];
            padHist[0] = bus.pad_i;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (checkEn) begin
            checkOutput("model_gpio", bus.gpio_o, expGpio);
            checkOutput("model_rise", bus.rise_o, expRise);
            checkOutput("model_fall", bus.fall_o, expFall);
            checkOutput("rise_fall_overlap", bus.rise_o & bus.fall_o, 32'h0);
        end
    end

    initial begin
        logic [31:0] pad;
        logic [31:0] en;
        logic [7:0]  thr;

        applyStimulus(32'h0, 32'h0, 8'd0);
        repeat (2) @(negedge clk);
        checkEn = 1'b1;

        // Pads toggling under reset must not reach the outputs.
        for (int c = 0; c < 5; c++) begin
            applyStimulus($urandom, 32'h0, 8'd0);
            @(negedge clk);
            checkOutput("reset_gpio", bus.gpio_o, 32'h0);
            checkOutput("reset_rise", bus.rise_o, 32'h0);
            checkOutput("reset_fall", bus.fall_o, 32'h0);
        end
        applyStimulus(32'h0, 32'h0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_reset_gpio", bus.gpio_o, 32'h0);

        // Bypass latency is SyncStages+1.
        applyStimulus(32'h0000_0008, 32'h0, 8'd0);
        repeat (2) @(negedge clk);
        checkOutput("bypass_gpio3_c2", 32'(bus.gpio_o[3]), 32'd0);
        @(negedge clk);
        checkOutput("bypass_gpio3_c3", 32'(bus.gpio_o[3]), 32'd1);
        checkOutput("bypass_rise3_c3", 32'(bus.rise_o[3]), 32'd1);
        @(negedge clk);
        checkOutput("bypass_rise3_c4", 32'(bus.rise_o[3]), 32'd0);

        // Debounce with threshold 5: a 4-cycle pulse is dropped, a steady level commits at 8.
        applyStimulus(32'h0, 32'hFFFF_FFFF, 8'd5);
        repeat (6) @(negedge clk);
        applyStimulus(32'h1, 32'hFFFF_FFFF, 8'd5);
        repeat (4) @(negedge clk);
        applyStimulus(32'h0, 32'hFFFF_FFFF, 8'd5);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("glitch_gpio0", 32'(bus.gpio_o[0]), 32'd0);
            checkOutput("glitch_rise0", 32'(bus.rise_o[0]), 32'd0);
        end
        applyStimulus(32'h1, 32'hFFFF_FFFF, 8'd5);
        repeat (7) @(negedge clk);
        checkOutput("debounce_gpio0_c7", 32'(bus.gpio_o[0]), 32'd0);
        @(negedge clk);
        checkOutput("debounce_gpio0_c8", 32'(bus.gpio_o[0]), 32'd1);
        checkOutput("debounce_rise0_c8", 32'(bus.rise_o[0]), 32'd1);

        // Maximum threshold: 256 differing cycles, no counter wrap.
        applyStimulus(32'h3, 32'hFFFF_FFFF, 8'd255);
        repeat (257) @(negedge clk);
        checkOutput("thr255_gpio1_c257", 32'(bus.gpio_o[1]), 32'd0);
        @(negedge clk);
        checkOutput("thr255_gpio1_c258", 32'(bus.gpio_o[1]), 32'd1);

        // Lowering the threshold below the running count commits on the next edge.
        applyStimulus(32'h7, 32'hFFFF_FFFF, 8'd200);
        repeat (52) @(negedge clk);
        checkOutput("lower_gpio2_before", 32'(bus.gpio_o[2]), 32'd0);
        applyStimulus(32'h7, 32'hFFFF_FFFF, 8'd10);
        @(negedge clk);
        checkOutput("lower_gpio2_after", 32'(bus.gpio_o[2]), 32'd1);

        // Dropping the filter enable mid-count passes the level straight through.
        applyStimulus(32'h87, 32'hFFFF_FFFF, 8'd20);
        repeat (10) @(negedge clk);
        checkOutput("mode_gpio7_counting", 32'(bus.gpio_o[7]), 32'd0);
        applyStimulus(32'h87, 32'hFFFF_FF7F, 8'd20);
        @(negedge clk);
        checkOutput("mode_gpio7", 32'(bus.gpio_o[7]), 32'd1);
        checkOutput("mode_rise7", 32'(bus.rise_o[7]), 32'd1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("mode_rise7_once", 32'(bus.rise_o[7]), 32'd0);
        end

        // All pins switching together in bypass.
        applyStimulus(32'h0, 32'h0, 8'd0);
        repeat (6) @(negedge clk);
        applyStimulus(32'hFFFF_FFFF, 32'h0, 8'd0);
        repeat (3) @(negedge clk);
        checkOutput("multi_rise", bus.rise_o, 32'hFFFF_FFFF);
        checkOutput("multi_gpio", bus.gpio_o, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("multi_rise_end", bus.rise_o, 32'h0);
        applyStimulus(32'h0, 32'h0, 8'd0);
        repeat (3) @(negedge clk);
        checkOutput("multi_fall", bus.fall_o, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("multi_fall_end", bus.fall_o, 32'h0);

        // Random traffic, including a reset pulse in the middle.
        pad = 32'h0;
        en  = $urandom;
        thr = 8'($urandom_range(0, 6));
        for (int c = 0; c < 3000; c++) begin
            pad = pad ^ ($urandom & $urandom & $urandom);
            if (c % 64 == 0) begin
                en  = $urandom;
                thr = 8'($urandom_range(0, 6));
            end else if ($urandom_range(0, 15) == 0) begin
                en = en ^ (32'h1 << $urandom_range(0, 31));
            end
            applyStimulus(pad, en, thr);
            if (c == 1500) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
